reg_file_alu_pipe: RTL
======================

// Module: reg_file_alu_pipe
// PURPOSE
//  Parametrised successor to the single-cycle register-file + ALU datapath.
//  Two-stage pipeline: ISSUE (operand read) then EXECUTE/WRITEBACK.
//  Adds a valid/ready issue handshake, RAW hazard handling, an extended op set
//  and a carry flag. Sits between the instruction decoder and the CPU output port.
// PARAMETERS
//  DATA_W    8  datapath width in bits (>=4)
//  ADDR_W    4  register address width; NREGS = 2**ADDR_W
//  ZERO_REG  0  1: register 0 reads as 0 and ignores writes
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous reset, active low
//  in_valid      in   1        issue request
//  in_ready      out  1        issue accepted when in_valid && in_ready at clk rise
//  ra1           in   ADDR_W   source A register
//  ra2           in   ADDR_W   source B register
//  wa            in   ADDR_W   destination register
//  immediate     in   DATA_W   immediate operand
//  alu_src       in   1        1: srcB = immediate, 0: srcB = reg[ra2]
//  alu_control   in   3        operation, see BEHAVIOUR
//  write_enable  in   1        write result to reg[wa]
//  out_valid     out  1        alu_result/zero/carry are valid this cycle
//  alu_result    out  DATA_W   registered ALU result
//  zero          out  1        alu_result == 0
//  carry         out  1        carry / no-borrow flag
//  cpu_out       out  DATA_W   last value written to the register file
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers, alu_result, cpu_out = 0;
//    out_valid, zero, carry = 0; EX stage flushed; in_ready = 0 while in reset.
//  - Reset mid-operation: the in-flight EX op is discarded and its write is lost.
//  - Issue at edge N: srcA/srcB are read and captured into EX regs.
//  - Edge N+1: alu_result, zero, carry registered; out_valid=1 for one cycle;
//    reg[wa] written if write_enable; cpu_out updated on that write only.
//  - Latency: 1 cycle. Throughput: 1 op/cycle. No output backpressure.
//  - alu_control:
//    000 add   001 sub   010 and   011 or   100 xor
//    101 slt   signed A<B -> 1, else 0
//    110 shl   A << srcB[$clog2(DATA_W)-1:0]
//    111 passB
//  - Arithmetic wraps modulo 2**DATA_W.
//    carry: add -> bit DATA_W of A+B; sub -> 1 when A>=B unsigned; other ops -> 0.
//  - zero is computed from the same result that is registered into alu_result.
//  - ZERO_REG=1: reads of addr 0 return 0; writes to addr 0 are dropped,
//    but alu_result still shows the computed value.
//  - RAW hazard: EX valid && EX write_enable && (ra1==EX.wa ||
//    (!alu_src && ra2==EX.wa)), and EX.wa not the ZERO_REG.
//    Handling depends on the macro, see CONFIGURATION.
//  - in_valid with in_ready low: the inputs must be held stable until accepted.
//  - Write and read of the same register at the same edge with no hazard path:
//    the read returns the old value.
// CONFIGURATION
//  REG_FILE_ALU_FWD_EN defined:
//    the EX result is bypassed combinationally to srcA/srcB on a hazard;
//    in_ready = 1 whenever out of reset.
//  REG_FILE_ALU_FWD_EN undefined:
//    in_ready = 0 for the hazard cycle (1-cycle stall);
//    the op issues next cycle with the written-back value.
//  Architectural results are identical in both builds; only the timing differs.
// TESTING
//  1. rst_n=0 for 2 cycles -> all outputs 0; every register reads 0 afterwards.
//  2. r0=r0+imm 0x07 (add, alu_src=1, we=1) -> next cycle out_valid=1,
//     alu_result=0x07, zero=0, cpu_out=0x07.
//  3. Back-to-back r1=r0+imm 5, then r2=r1+r1 -> r1=0x0C, r2=0x18.
//     FWD_EN: no stall. Without FWD_EN: in_ready low exactly 1 cycle.
//  4. sub r3=r1-r1 -> alu_result=0, zero=1, carry=1;
//     then r4 = 0xFF + imm 0x01 (add) -> alu_result=0x00, zero=1, carry=1.
//  5. slt with A=0x80, B=0x01 -> 1; shl 0x03 by 2 -> 0x0C; passB imm 0xA5 -> 0xA5.
//  6. ZERO_REG=1: write r0<=5, then read r0 -> 0.
//     Assert rst_n mid-EX -> out_valid=0, target register unchanged (0).

Source files
------------

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register-file + ALU pipeline: ISSUE reads operands, EXECUTE computes and writes back.
// Optional macro REG_FILE_ALU_FWD_EN: bypass the EX result on a RAW hazard instead of stalling.
module reg_file_alu_pipe #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] immediate,
    input  logic              alu_src,
    input  logic [2:0]        alu_control,
    input  logic              write_enable,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              carry,
    output logic [DATA_W-1:0] cpu_out
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int SH_W  = $clog2(DATA_W);

    logic [DATA_W-1:0] regs [NREGS];

    logic              ex_valid_reg;
    logic [DATA_W-1:0] ex_a_reg;
    logic [DATA_W-1:0] ex_b_reg;
    logic [2:0]        ex_op_reg;
    logic              ex_we_reg;
    logic [ADDR_W-1:0] ex_wa_reg;

    logic              out_valid_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic              zero_reg;
    logic              carry_reg;
    logic [DATA_W-1:0] cpu_out_reg;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              wb_en;
    logic [NREGS-1:0]  reg_we;
    logic              hit_a;
    logic              hit_b;
    logic              hazard;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              issue_fire;

    // A write to the hard-wired zero register is not a real write, so it can't cause a hazard.
    assign wb_en  = ex_valid_reg && ex_we_reg && !(ZERO_REG != 0 && ex_wa_reg == '0);
    assign hit_a  = wb_en && (ra1 == ex_wa_reg);
    assign hit_b  = wb_en && !alu_src && (ra2 == ex_wa_reg);
    assign hazard = hit_a || hit_b;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
            assign reg_we[gi] = wb_en && (ex_wa_reg == ADDR_W'(gi));
        end
    endgenerate

    assign rd_a = (ZERO_REG != 0 && ra1 == '0) ? '0 : regs[ra1];
    assign rd_b = (ZERO_REG != 0 && ra2 == '0) ? '0 : regs[ra2];

`ifdef REG_FILE_ALU_FWD_EN
    assign in_ready = rst_n;
    assign src_a    = hit_a ? alu_res : rd_a;
    assign src_b    = alu_src ? immediate : (hit_b ? alu_res : rd_b);
`else
    // Hold off for one cycle so the register file catches the pending write.
    assign in_ready = rst_n && !hazard;
    assign src_a    = rd_a;
    assign src_b    = alu_src ? immediate : rd_b;
`endif

    assign issue_fire = in_valid && in_ready;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (ex_op_reg)
            3'b000: {alu_carry, alu_res} = {1'b0, ex_a_reg} + {1'b0, ex_b_reg};
            3'b001: begin
                alu_res   = ex_a_reg - ex_b_reg;
                alu_carry = (ex_a_reg >= ex_b_reg);
            end
            3'b010: alu_res = ex_a_reg & ex_b_reg;
            3'b011: alu_res = ex_a_reg | ex_b_reg;
            3'b100: alu_res = ex_a_reg ^ ex_b_reg;
            3'b101: alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a_reg) < $signed(ex_b_reg))};
            3'b110: alu_res = ex_a_reg << ex_b_reg[SH_W-1:0];
            default: alu_res = ex_b_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_op_reg    <= '0;
            ex_we_reg    <= 1'b0;
            ex_wa_reg    <= '0;
        end else begin
            ex_valid_reg <= issue_fire;
            if (issue_fire) begin
                ex_a_reg  <= src_a;
                ex_b_reg  <= src_b;
                ex_op_reg <= alu_control;
                ex_we_reg <= write_enable;
                ex_wa_reg <= wa;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            alu_result_reg <= '0;
            zero_reg       <= 1'b0;
            carry_reg      <= 1'b0;
            cpu_out_reg    <= '0;
        end else begin
            out_valid_reg <= ex_valid_reg;
            if (ex_valid_reg) begin
                alu_result_reg <= alu_res;
                zero_reg       <= (alu_res == '0);
                carry_reg      <= alu_carry;
            end
            if (wb_en) begin
                cpu_out_reg <= alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we[i]) begin
                    regs[i] <= alu_res;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign alu_result = alu_result_reg;
    assign zero       = zero_reg;
    assign carry      = carry_reg;
    assign cpu_out    = cpu_out_reg;

endmodule
